// File: rtl/cluster_event_pkg.sv
// Shared types and event-map constants for the per-core cluster event decoder.
package cluster_event_pkg;

  typedef enum logic [1:0] {
    EVT_IDLE  = 2'd0,
    EVT_SLEEP = 2'd1,
    EVT_WAKE  = 2'd2,
    EVT_ACK   = 2'd3
  } evt_fsm_e;

  localparam int EVT_ID_W = 5;

  // Bit positions of each event source within the mapped cluster event vector.
  localparam int EVT_SW_LSB       = 0;
  localparam int EVT_SW_MSB       = 7;
  localparam int EVT_DMA_LSB      = 8;
  localparam int EVT_DMA_MSB      = 9;
  localparam int EVT_TIMER_LSB    = 10;
  localparam int EVT_TIMER_MSB    = 11;
  localparam int EVT_ACC_LSB      = 12;
  localparam int EVT_ACC_MSB      = 15;
  localparam int EVT_BARRIER_BIT  = 16;
  localparam int EVT_MUTEX_BIT    = 17;
  localparam int EVT_DISPATCH_BIT = 18;
  localparam int EVT_CLUSTER_LSB  = 22;
  localparam int EVT_CLUSTER_MSB  = 24;
  localparam int EVT_PERIPH_FIFO_BIT = 27;

endpackage

// File: rtl/cluster_event_prio_enc.sv
// Combinational lowest-set-bit encoder: reports the index of the lowest set bit of vec_i.
module cluster_event_prio_enc import cluster_event_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int ID_W  = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic [ID_W-1:0]  id,
  output logic             valid
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    id    = '0;
    valid = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      id    = vec_i[i] ? ID_W'(i) : id;
      valid = vec_i[i] | valid;
    end
  end

endmodule

// File: rtl/cluster_event_decoder.sv
// Per-core event consumer: pending buffer, mask filter, wait-for-event FSM with clock gating,
// and a saturating counter of events lost to overflow.
module cluster_event_decoder import cluster_event_pkg::*; #(
  parameter int EVT_WIDTH = 32,
  parameter int CNT_WIDTH = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [EVT_WIDTH-1:0]         events_i,
  input  logic                         mask_we_i,
  input  logic [EVT_WIDTH-1:0]         mask_wdata_i,
  input  logic                         clr_we_i,
  input  logic [EVT_WIDTH-1:0]         clr_wdata_i,
  input  logic                         evt_req_i,
  output logic                         evt_valid_o,
  output logic [$clog2(EVT_WIDTH)-1:0] evt_id_o,
  output logic                         core_clk_en_o,
  output logic [EVT_WIDTH-1:0]         pending_o,
  output logic [EVT_WIDTH-1:0]         mask_o,
  output logic [CNT_WIDTH-1:0]         ovf_cnt_o
);

  localparam int ID_W = $clog2(EVT_WIDTH);

  evt_fsm_e               state_q;
  logic [EVT_WIDTH-1:0]   pending_q, pending_d;
  logic [EVT_WIDTH-1:0]   mask_q;
  logic [CNT_WIDTH-1:0]   ovf_q;
  logic                   valid_q;
  logic [ID_W-1:0]        id_q;
  logic                   clk_en_q;

  logic [EVT_WIDTH-1:0]   match_s;
  logic [ID_W-1:0]        win_id_s;
  logic                   win_valid_s;
  logic                   take_s;
  logic [EVT_WIDTH-1:0]   clr_s;
  logic                   ovf_hit_s;

  assign match_s = pending_q & mask_q;

  cluster_event_prio_enc #(
    .WIDTH (EVT_WIDTH),
    .ID_W  (ID_W)
  ) u_prio_enc (
    .vec_i (match_s),
    .id    (win_id_s),
    .valid (win_valid_s)
  );

  // Consume the winner on an IDLE hit or in WAKE; the consumed bit joins the clear set.
  always_comb begin
    take_s = win_valid_s && (((state_q == EVT_IDLE) && evt_req_i) || (state_q == EVT_WAKE));
    if (clr_we_i) begin
      clr_s = clr_wdata_i;
    end else begin
      clr_s = '0;
    end
    if (take_s) begin
      clr_s = clr_s | ({{(EVT_WIDTH-1){1'b0}}, 1'b1} << win_id_s);
    end else begin
      clr_s = clr_s;
    end
    ovf_hit_s = |(events_i & pending_q & ~clr_s);
    pending_d = (pending_q & ~clr_s) | events_i;
  end

  // Pending buffer, mask register and saturating overflow counter.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pending_q <= '0;
      mask_q    <= '0;
      ovf_q     <= '0;
    end else begin
      pending_q <= pending_d;
      if (mask_we_i) begin
        mask_q <= mask_wdata_i;
      end
      if (ovf_hit_s && (ovf_q != {CNT_WIDTH{1'b1}})) begin
        ovf_q <= ovf_q + CNT_WIDTH'(1);
      end
    end
  end

  // Wait-for-event FSM with registered valid/id/clock-enable outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= EVT_IDLE;
      valid_q  <= 1'b0;
      id_q     <= '0;
      clk_en_q <= 1'b1;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        EVT_IDLE: begin
          if (evt_req_i && win_valid_s) begin
            state_q <= EVT_ACK;
            id_q    <= win_id_s;
            valid_q <= 1'b1;
          end else if (evt_req_i) begin
            state_q  <= EVT_SLEEP;
            clk_en_q <= 1'b0;
          end else begin
            state_q <= EVT_IDLE;
          end
        end
        EVT_SLEEP: begin
          if (win_valid_s) begin
            state_q  <= EVT_WAKE;
            clk_en_q <= 1'b1;
          end else if (!evt_req_i) begin
            state_q  <= EVT_IDLE;
            clk_en_q <= 1'b1;
          end else begin
            state_q <= EVT_SLEEP;
          end
        end
        EVT_WAKE: begin
          // A match withdrawn during WAKE (clear or mask change) returns to waiting.
          if (win_valid_s) begin
            state_q <= EVT_ACK;
            id_q    <= win_id_s;
            valid_q <= 1'b1;
          end else if (evt_req_i) begin
            state_q  <= EVT_SLEEP;
            clk_en_q <= 1'b0;
          end else begin
            state_q <= EVT_IDLE;
          end
        end
        EVT_ACK: begin
          state_q <= EVT_IDLE;
        end
        default: begin
          state_q  <= EVT_IDLE;
          clk_en_q <= 1'b1;
        end
      endcase
    end
  end

  assign evt_valid_o   = valid_q;
  assign evt_id_o      = id_q;
  assign core_clk_en_o = clk_en_q;
  assign pending_o     = pending_q;
  assign mask_o        = mask_q;
  assign ovf_cnt_o     = ovf_q;

endmodule

// File: tb/tb_cluster_event_decoder.sv
// Randomized + directed bench for cluster_event_decoder with a cycle-level reference model
// and a queue-based scoreboard consumed by an independent negedge monitor.
module tb_cluster_event_decoder;
  import cluster_event_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ev, mwd, cwd;
  logic        mwe, cwe, req;
  logic        evt_valid;
  logic [4:0]  evt_id;
  logic        clk_en;
  logic [31:0] pend, mask;
  logic [7:0]  ovf;

  cluster_event_decoder dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .events_i     (ev),
    .mask_we_i    (mwe),
    .mask_wdata_i (mwd),
    .clr_we_i     (cwe),
    .clr_wdata_i  (cwd),
    .evt_req_i    (req),
    .evt_valid_o  (evt_valid),
    .evt_id_o     (evt_id),
    .core_clk_en_o(clk_en),
    .pending_o    (pend),
    .mask_o       (mask),
    .ovf_cnt_o    (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [31:0] id;
    logic        clken;
    logic [31:0] pend;
    logic [31:0] mask;
    logic [31:0] ovf;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] rsp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  // Reference model: 0 idle, 1 sleeping, 2 waking, 3 acknowledging.
  int          m_phase;
  logic [31:0] m_pend, m_mask, m_id;
  int          m_ovf;
  logic        m_valid, m_clken;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic model_step();
    logic [31:0] match, lowbit, clr;
    logic        take;
    if (!rst_n) begin
      m_phase = 0; m_pend = 32'd0; m_mask = 32'd0; m_id = 32'd0;
      m_ovf = 0; m_valid = 1'b0; m_clken = 1'b1;
      return;
    end
    match  = m_pend & m_mask;
    lowbit = match & (~match + 32'd1);
    take   = (match != 32'd0) && ((m_phase == 0 && req) || m_phase == 2);
    clr    = (cwe ? cwd : 32'd0) | (take ? lowbit : 32'd0);
    if (((ev & m_pend & ~clr) != 32'd0) && m_ovf < 255) m_ovf++;
    m_pend  = (m_pend & ~clr) | ev;
    m_valid = 1'b0;
    if (take) begin
      m_phase = 3; m_id = $clog2(lowbit); m_valid = 1'b1;
      rsp_q.push_back(m_id);
    end else if (m_phase == 0) begin
      if (req) m_phase = 1;
    end else if (m_phase == 1) begin
      if (match != 32'd0) m_phase = 2;
      else if (!req) m_phase = 0;
    end else if (m_phase == 2) begin
      m_phase = req ? 1 : 0;
    end else begin
      m_phase = 0;
    end
    if (mwe) m_mask = mwd;
    m_clken = (m_phase != 1);
  endtask

  task automatic cyc();
    exp_t e;
    @(posedge clk);
    #1;
    model_step();
    e.valid = m_valid; e.id = m_id; e.clken = m_clken;
    e.pend = m_pend; e.mask = m_mask; e.ovf = m_ovf;
    exp_q.push_back(e);
    ev = 32'd0; mwe = 1'b0; cwe = 1'b0;
  endtask

  task automatic cycn(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  // Monitor: compare every cycle's outputs and pop a response whenever the DUT presents one.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("valid", {31'd0, evt_valid}, {31'd0, e.valid});
      chk("clk_en", {31'd0, clk_en}, {31'd0, e.clken});
      chk("pending", pend, e.pend);
      chk("mask", mask, e.mask);
      chk("ovf_cnt", {24'd0, ovf}, e.ovf);
      if (e.valid) chk("id_reg", {27'd0, evt_id}, e.id);
    end
    if (evt_valid === 1'b1) begin
      if (rsp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL rsp_unexpected: got id %0d expected no response", evt_id);
      end else begin
        chk("rsp_id", {27'd0, evt_id}, rsp_q.pop_front());
      end
    end
  end

  initial begin
    rst_n = 1'b0; ev = 32'd0; mwd = 32'd0; cwd = 32'd0;
    mwe = 1'b0; cwe = 1'b0; req = 1'b0;
    cycn(2);
    chk("rst_valid", {31'd0, evt_valid}, 32'd0);
    chk("rst_id", {27'd0, evt_id}, 32'd0);
    chk("rst_clken", {31'd0, clk_en}, 32'd1);
    chk("rst_pend", pend, 32'd0);
    chk("rst_ovf", {24'd0, ovf}, 32'd0);
    rst_n = 1'b1;

    // Hit
    mwe = 1'b1; mwd = 32'h0000_0100; cyc();
    ev = 32'd1 << EVT_DMA_LSB; cyc();
    chk("hit_pend_set", pend, 32'h0000_0100);
    req = 1'b1; cyc();
    chk("hit_valid", {31'd0, evt_valid}, 32'd1);
    chk("hit_id", {27'd0, evt_id}, 32'd8);
    chk("hit_pend_clr", pend, 32'd0);
    chk("hit_clken", {31'd0, clk_en}, 32'd1);
    req = 1'b0; cyc();

    // Sleep / wake
    mwe = 1'b1; mwd = 32'h0001_0000; cyc();
    req = 1'b1; cyc();
    chk("sleep_clken", {31'd0, clk_en}, 32'd0);
    cycn(4);
    ev = 32'd1 << EVT_BARRIER_BIT; cyc();
    chk("sleep_still", {31'd0, clk_en}, 32'd0);
    cyc();
    chk("wake_clken", {31'd0, clk_en}, 32'd1);
    chk("wake_novalid", {31'd0, evt_valid}, 32'd0);
    cyc();
    chk("wake_valid", {31'd0, evt_valid}, 32'd1);
    chk("wake_id", {27'd0, evt_id}, 32'd16);
    req = 1'b0; cyc();

    // Priority and masking
    mwe = 1'b1; mwd = 32'h0000_0C00; ev = 32'h0000_0C01; cyc();
    req = 1'b1; cyc();
    chk("prio_id0", {27'd0, evt_id}, EVT_TIMER_LSB);
    req = 1'b0; cyc();
    req = 1'b1; cyc();
    chk("prio_id1", {27'd0, evt_id}, 32'd11);
    req = 1'b0; cyc();
    chk("prio_left", pend, 32'h0000_0001);

    // Overflow and clear collision
    ev = 32'h8; cyc();
    ev = 32'h8; cyc();
    chk("ovf_one", {24'd0, ovf}, 32'd1);
    ev = 32'h8; cwe = 1'b1; cwd = 32'h8; cyc();
    chk("ovf_clr_pend", pend & 32'h8, 32'h8);
    chk("ovf_clr_cnt", {24'd0, ovf}, 32'd1);
    for (int i = 0; i < 300; i++) begin
      ev = 32'h8; cyc();
    end
    chk("ovf_sat", {24'd0, ovf}, 32'd255);

    // Abort, then unmask-during-sleep wake
    cwe = 1'b1; cwd = 32'hFFFF_FFFF; mwe = 1'b1; mwd = 32'd0; cyc();
    req = 1'b1; cycn(2);
    req = 1'b0; cyc();
    chk("abort_clken", {31'd0, clk_en}, 32'd1);
    chk("abort_novalid", {31'd0, evt_valid}, 32'd0);
    ev = 32'h20; cyc();
    req = 1'b1; cycn(2);
    mwe = 1'b1; mwd = 32'h20; cyc();
    cycn(2);
    chk("unmask_valid", {31'd0, evt_valid}, 32'd1);
    chk("unmask_id", {27'd0, evt_id}, 32'd5);
    req = 1'b0; cyc();

    // Reset mid-SLEEP
    ev = 32'h2; req = 1'b1; cycn(2);
    rst_n = 1'b0; cyc();
    chk("rst2_clken", {31'd0, clk_en}, 32'd1);
    chk("rst2_pend", pend, 32'd0);
    chk("rst2_ovf", {24'd0, ovf}, 32'd0);
    rst_n = 1'b1; req = 1'b0; cycn(3);

    // Randomized traffic following the request/acknowledge protocol
    for (int i = 0; i < 3000; i++) begin
      ev = $urandom & $urandom & $urandom;
      if ($urandom_range(0, 19) == 0) begin mwe = 1'b1; mwd = $urandom & $urandom; end
      if ($urandom_range(0, 19) == 0) begin cwe = 1'b1; cwd = $urandom; end
      rst_n = ($urandom_range(0, 499) != 0);
      if (!req) req = ($urandom_range(0, 3) == 0);
      else if (m_phase == 1 && $urandom_range(0, 49) == 0) req = 1'b0;
      cyc();
      if (m_valid) req = 1'b0;
    end
    rst_n = 1'b1; req = 1'b0;
    cycn(3);
    @(negedge clk);
    #1;
    chk("rsp_drain", rsp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cluster_event_decoder.md
# cluster_event_decoder

Per-core consumer of the mapped cluster event vector. It latches incoming event pulses into a pending buffer, filters them through a software-programmed mask, and serves the core's wait-for-event request by returning the lowest-numbered pending masked event ID. It gates the core clock while the core waits, and counts events lost to overflow. One instance sits between each core's slice of the cluster event map and that core's event/sleep interface.

## Interface
- `EVT_WIDTH`, default 32: width of the mapped event vector.
- `CNT_WIDTH`, default 8: width of the saturating overflow counter.
- `clk_i`, in, 1: cluster clock.
- `rst_ni`, in, 1: reset, synchronous, active-low.
- `events_i`, in, `EVT_WIDTH`: mapped event pulses, one cycle each.
- `mask_we_i`, in, 1: write strobe for the mask register.
- `mask_wdata_i`, in, `EVT_WIDTH`: new mask value.
- `clr_we_i`, in, 1: strobe for software clear of pending bits.
- `clr_wdata_i`, in, `EVT_WIDTH`: pending bits to clear (1 = clear).
- `evt_req_i`, in, 1: core waits for an event; held high until `evt_valid_o`.
- `evt_valid_o`, out, 1: one-cycle response; `evt_id_o` is valid.
- `evt_id_o`, out, `$clog2(EVT_WIDTH)`: ID of the event being consumed.
- `core_clk_en_o`, out, 1: core clock enable; low only while sleeping.
- `pending_o`, out, `EVT_WIDTH`: pending buffer, readable by software.
- `mask_o`, out, `EVT_WIDTH`: current mask.
- `ovf_cnt_o`, out, `CNT_WIDTH`: count of lost events, saturating.

## Operation
- Pending update each cycle: `pending_next = (pending & ~clr) | events_i`, where `clr` = `clr_wdata_i` when `clr_we_i`, plus the bit consumed by an ACK.
  - Set wins over clear for the same bit, so no new event is dropped.
- Overflow: an event arriving on a bit that is already pending and not being cleared this cycle increments `ovf_cnt`. Several such bits in one cycle add 1 in total. The counter saturates at all-ones.
- `match = pending & mask`. The winner is the lowest-index set bit of `match`.
- FSM states are IDLE, SLEEP, WAKE, ACK.
- IDLE:
  - `evt_req_i` and `match != 0`: go to ACK. Latch the winner ID and clear that pending bit.
  - `evt_req_i` and `match == 0`: go to SLEEP.
  - Otherwise stay in IDLE.
- SLEEP:
  - `core_clk_en_o` = 0.
  - `match != 0`: go to WAKE.
  - `evt_req_i` dropped (abort, e.g. an interrupt): go to IDLE.
  - Match takes priority over abort when both occur.
- WAKE:
  - `core_clk_en_o` = 1. This gives one cycle for the clock gate to open.
  - Recompute the winner, latch its ID, clear its bit, and go to ACK.
- ACK:
  - `evt_valid_o` = 1 and `evt_id_o` = the latched ID, for exactly one cycle.
  - Go to IDLE.
- After ACK the core must drop `evt_req_i`. If `evt_req_i` is still high in IDLE, it is a new request.
- Mask writes take effect on the next cycle's match. A mask write during SLEEP that unmasks a pending bit causes a wake.

## Timing
- Reset values:
  - `evt_valid_o` = 0, `evt_id_o` = 0.
  - `core_clk_en_o` = 1.
  - `pending_o` = 0, `mask_o` = 0, `ovf_cnt_o` = 0.
  - FSM = IDLE.
- An event pulse at cycle t is visible in `pending_o` at t+1.
- Hit latency: request sampled in IDLE at t with a match gives `evt_valid_o` at t+1.
- Sleep path:
  - Request at t with no match: `core_clk_en_o` low from t+1.
  - Event at t+k: pending at t+k+1, WAKE at t+k+2 (`core_clk_en_o` high), `evt_valid_o` at t+k+3.
- All outputs are registered; no combinational path from inputs to outputs.
- A reset asserted mid-SLEEP or mid-ACK forces the reset values on the next edge. No response is emitted.

## Structure
- Shared package `cluster_event_pkg` holds:
  - `evt_fsm_e` enum.
  - `EVT_ID_W`.
  - The event bit-position constants (SW 7:0, DMA 9:8, TIMER 11:10, ACC 15:12, BARRIER 16, MUTEX 17, DISPATCH 18, CLUSTER 24:22, PERIPH_FIFO 27).
- Sub-module `cluster_event_prio_enc`: combinational lowest-set-bit encoder with outputs `id` and `valid`.

## Test plan
- Hit: after reset, mask = 0x0000_0100, pulse bit 8, then raise req → `evt_valid_o` one cycle later with `evt_id_o` = 8, `pending_o` = 0, `core_clk_en_o` stays 1.
- Sleep/wake: mask = 0x0001_0000, raise req with nothing pending → `core_clk_en_o` = 0. Pulse bit 16 five cycles later → clk_en high 2 cycles after the pulse, valid with ID 16 on the 3rd.
- Priority and masking: pending = 0x0000_0C01, mask = 0x0000_0C00 → two requests return IDs 10, then 11; bit 0 remains pending.
- Overflow and clear collision: pulse bit 3 twice → `ovf_cnt_o` = 1. Pulse bit 3 together with a clear of 0x8 → bit 3 still pending, count unchanged. 300 collisions → count saturates at 255.
- Abort: enter SLEEP, drop req → back to IDLE with `core_clk_en_o` = 1 and no `evt_valid_o`. Unmask a pending bit during SLEEP → wake and valid with that ID.
- Reset mid-SLEEP: pull `rst_ni` low for one cycle → all outputs at their reset values on the next edge; no valid pulse follows.
